sha3_pad_blk: RTL

Upstream feeder for the Keccak permutation block. Accepts a message as a stream of 64-bit little-endian words with byte counts, applies SHA-3 multi-rate padding, and emits each rate block as a 25-lane stream. Each block is RATE_LANES message/pad lanes followed by zero capacity lanes, one lane per beat, in the order x0y0, x1y0 … x4y4 (lane index l = x + 5y). Output handshake is pushout/stopout with firstout marking a message's first lane, matching the permutation block's input port.

---
 rtl/sha3_pad_blk.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sha3_pad_blk.sv
// SHA-3 multi-rate padder: packs a byte-counted 64-bit word stream into 25-lane Keccak blocks.
// Define PADDER_SHAKE_EN to pad with the SHAKE domain byte 0x1F instead of the SHA-3 byte 0x06.
module sha3_pad_blk #(
    parameter int unsigned RATE_LANES = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pushin,
    output logic        stopin,
    input  logic        firstin,
    input  logic        lastin,
    input  logic [3:0]  nbytes,
    input  logic [63:0] din,
    output logic        pushout,
    input  logic        stopout,
    output logic        firstout,
    output logic        lastout,
    output logic [63:0] dout
);
`ifdef PADDER_SHAKE_EN
    localparam logic [7:0] PadD = 8'h1F;
`else
    localparam logic [7:0] PadD = 8'h06;
`endif
    localparam logic [4:0]  LastRate = 5'(RATE_LANES - 1);
    localparam logic [4:0]  LastLane = 5'd24;
    localparam logic [63:0] PadTop   = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {StIdle, StData, StPad, StCap} state_e;

    state_e      state_q;
    logic [4:0]  lane_q;
    logic        pushout_q, firstout_q, lastout_q;
    logic [63:0] dout_q;
    logic        msg_end_q;   // last word of the message has been taken
    logic        pad_done_q;  // final 0x80 has been emitted; this block ends the message
    logic        d_placed_q;  // domain byte already emitted

    logic        load, accept, rate_end;
    logic [3:0]  nb;
    logic [63:0] byte_mask, word_pad, pad_lane;
    logic [4:0]  lane_inc;

    always_comb begin
        load     = !pushout_q || !stopout;
        stopin   = (state_q != StIdle && state_q != StData) || (pushout_q && stopout);
        accept   = pushin && !stopin;
        rate_end = (lane_q == LastRate);
        lane_inc = (lane_q == LastLane) ? 5'd0 : lane_q + 5'd1;
        nb       = (!lastin || nbytes > 4'd8) ? 4'd8 : nbytes;
        for (int k = 0; k < 8; k++) begin
            byte_mask[8*k +: 8] = (4'(k) < nb) ? 8'hFF : 8'h00;
        end
        // A shift by 64 (nb == 8) yields zero, so a full last word gets no in-lane D.
        word_pad = (din & byte_mask);
        if (lastin) begin
            word_pad = word_pad | (64'(PadD) << {nb, 3'b000});
            if (rate_end && nb != 4'd8) begin
                word_pad = word_pad | PadTop;
            end
        end
        pad_lane = d_placed_q ? 64'h0 : 64'(PadD);
        if (rate_end) begin
            pad_lane = pad_lane | PadTop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            lane_q     <= '0;
            pushout_q  <= 1'b0;
            firstout_q <= 1'b0;
            lastout_q  <= 1'b0;
            dout_q     <= '0;
            msg_end_q  <= 1'b0;
            pad_done_q <= 1'b0;
            d_placed_q <= 1'b0;
        end else if (load) begin
            pushout_q  <= 1'b0;
            firstout_q <= 1'b0;
            lastout_q  <= 1'b0;
            unique case (state_q)
                StIdle, StData: begin
                    // In IDLE only a word flagged firstin opens a message; others are dropped.
                    if (accept && (state_q == StData || firstin)) begin
                        pushout_q  <= 1'b1;
                        firstout_q <= (state_q == StIdle);
                        dout_q     <= word_pad;
                        lane_q     <= lane_inc;
                        msg_end_q  <= lastin;
                        d_placed_q <= lastin && (nb != 4'd8);
                        pad_done_q <= lastin && (nb != 4'd8) && rate_end;
                        if (rate_end) begin
                            state_q <= StCap;
                        end else if (lastin) begin
                            state_q <= StPad;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StPad: begin
                    pushout_q  <= 1'b1;
                    dout_q     <= pad_lane;
                    d_placed_q <= 1'b1;
                    lane_q     <= lane_inc;
                    if (rate_end) begin
                        state_q    <= StCap;
                        pad_done_q <= 1'b1;
                    end
                end
                StCap: begin
                    pushout_q <= 1'b1;
                    dout_q    <= '0;
                    lane_q    <= lane_inc;
                    if (lane_q == LastLane) begin
                        lastout_q <= pad_done_q;
                        if (pad_done_q) begin
                            state_q <= StIdle;
                        end else if (msg_end_q) begin
                            state_q <= StPad;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
            endcase
        end
    end

    assign pushout  = pushout_q;
    assign firstout = firstout_q;
    assign lastout  = lastout_q;
    assign dout     = dout_q;

endmodule
